// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg
//   Shared definitions for the single-precision square-root sequencer:
//   FSM state encoding, exponent bias, canned special results, rounding-mode
//   codes and the round-increment decision.
//   Optional feature macro used by the design: FSQRT_DENORM_EN.
package fsqrt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  localparam int          BIAS          = 127;
  localparam logic [31:0] QNAN          = 32'h7FC0_0000;
  localparam logic [31:0] PINF          = 32'h7F80_0000;
  localparam int          DRAIN_CYC_DEF = 3;

  // The root is always positive, so RDN behaves like RTZ and RUP rounds away
  // from zero whenever any discarded bit is set.
  function automatic logic round_inc(input rm_e rm, input logic lsb,
                                     input logic guard, input logic sticky);
    logic inc;
    case (rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RUP:  inc = guard | sticky;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fsqrt_ctrl_if.sv
// fsqrt_ctrl_if
//   Pipeline-side bundle of the square-root sequencer.
//   master (pipeline): drives fsqrt, a, rm, ena; receives s, invalid, valid,
//                      stall, busy.
//   slave  (sequencer): the reverse directions.
//   fsqrt   - issue request, sampled only while the sequencer is idle
//   a       - IEEE-754 single operand, sampled with the issue
//   rm      - rounding mode (00 RNE, 01 RTZ, 10 RUP, 11 RDN)
//   ena     - pipeline enable, also advances the root core's output stages
//   s       - packed result, holds until the next result
//   invalid - invalid-operation flag, meaningful only with valid
//   valid   - one-cycle result strobe
//   stall   - pipeline stall
//   busy    - sequencer not idle
interface fsqrt_ctrl_if;
  logic        fsqrt;
  logic [31:0] a;
  logic [1:0]  rm;
  logic        ena;
  logic [31:0] s;
  logic        invalid;
  logic        valid;
  logic        stall;
  logic        busy;

  modport master (
    output fsqrt, a, rm, ena,
    input  s, invalid, valid, stall, busy
  );

  modport slave (
    input  fsqrt, a, rm, ena,
    output s, invalid, valid, stall, busy
  );
endinterface

// File: rtl/fsqrt_ctrl_lzc23.sv
// lzc23
//   Combinational leading-zero counter over a 23-bit fraction. Used to
//   normalize denormal operands; only compiled when FSQRT_DENORM_EN is defined
//   so builds without denormal support carry no unused module.
//   f_i   in  23 : fraction field
//   lzc_o out  5 : number of leading zeros (23 when f_i is zero)
`ifdef FSQRT_DENORM_EN
module lzc23 (
  input  logic [22:0] f_i,
  output logic [4:0]  lzc_o
);

  // Scan upward; the highest set bit is seen last and wins.
  always_comb begin
    lzc_o = 5'd23;
    for (int i = 0; i < 23; i++) begin
      if (f_i[i]) begin
        lzc_o = 5'(22 - i);
      end
    end
  end

endmodule
`endif

// File: rtl/fsqrt_ctrl.sv
// fsqrt_ctrl
//   IEEE-754 single-precision square-root sequencer. Takes an fsqrt issue,
//   classifies the operand, answers special operands directly, otherwise
//   prepares a 24-bit fraction for the iterative root core, stalls the
//   pipeline while the core runs and drains, then normalizes and rounds the
//   core's 32-bit root into the packed result.
//   Optional feature: FSQRT_DENORM_EN (defined: denormal operands are
//   normalized and computed; undefined: they flush to a signed zero).
// Ports
//   clk        in      : clock
//   clrn       in      : asynchronous active-low reset (shared with the core)
//   pif        slave   : pipeline bundle (fsqrt, a, rm, ena / s, invalid,
//                        valid, stall, busy)
//   core_busy  in      : root core busy
//   core_q     in  32  : root, value core_q * 2^-31, bit 0 sticky
//   core_d     out 24  : fraction to the core, value core_d * 2^-24
//   core_fsqrt out     : one-cycle start pulse to the core
// Parameter
//   DRAIN_CYC          : ena-qualified cycles after core_busy falls until
//                        core_q is valid (must be >= 1)
module fsqrt_ctrl
  import fsqrt_pkg::*;
#(
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                clk,
  input  logic                clrn,
  fsqrt_ctrl_if.slave         pif,
  input  logic                core_busy,
  input  logic [31:0]         core_q,
  output logic [23:0]         core_d,
  output logic                core_fsqrt
);

  localparam int CW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  // ---------------------------------------------------------------------
  // Operand decode (combinational on the issue-time operand)
  // ---------------------------------------------------------------------
  logic        op_sign;
  logic [7:0]  op_exp;
  logic [22:0] op_frac;
  logic        exp_zero;
  logic        exp_ones;
  logic        frac_nz;
  logic        zero_like;

  assign op_sign  = pif.a[31];
  assign op_exp   = pif.a[30:23];
  assign op_frac  = pif.a[22:0];
  assign exp_zero = (op_exp == 8'h00);
  assign exp_ones = (op_exp == 8'hFF);
  assign frac_nz  = (op_frac != 23'd0);

`ifdef FSQRT_DENORM_EN
  assign zero_like = exp_zero & ~frac_nz;
`else
  // Denormals are flushed, so any zero exponent resolves as a signed zero.
  assign zero_like = exp_zero;
`endif

  // Special-case resolution; priority keeps NaN quiet even when negative.
  logic        spec_hit;
  logic        spec_inv;
  logic [31:0] spec_res;

  always_comb begin
    spec_hit = 1'b0;
    spec_inv = 1'b0;
    spec_res = 32'd0;
    if (exp_ones & frac_nz) begin
      spec_hit = 1'b1;
      spec_res = QNAN;
    end else if (zero_like) begin
      spec_hit = 1'b1;
      spec_res = {op_sign, 31'd0};
    end else if (op_sign) begin
      spec_hit = 1'b1;
      spec_inv = 1'b1;
      spec_res = QNAN;
    end else if (exp_ones) begin
      spec_hit = 1'b1;
      spec_res = PINF;
    end
  end

  // ---------------------------------------------------------------------
  // Operand preparation: value = 1.f * 2^E
  // ---------------------------------------------------------------------
  logic        [22:0] norm_frac;
  logic signed [9:0]  unb_exp;

`ifdef FSQRT_DENORM_EN
  logic [4:0] lzc;

  lzc23 u_lzc23 (
    .f_i   (op_frac),
    .lzc_o (lzc)
  );
`endif

  always_comb begin
    norm_frac = op_frac;
    unb_exp   = $signed({2'b00, op_exp}) - 10'(BIAS);
`ifdef FSQRT_DENORM_EN
    // Shifting past the leading one moves it into the hidden-bit position.
    if (exp_zero) begin
      norm_frac = op_frac << (lzc + 5'd1);
      unb_exp   = -10'sd127 - $signed({5'd0, lzc});
    end
`endif
  end

  // Fold E+1 into an even power of two so the core sees a fraction in
  // [0.25,1): even E+1 -> 1.f/2, odd E+1 -> 1.f/4 (f[0] is dropped).
  logic signed [9:0] e_plus1;
  logic signed [9:0] root_exp;
  logic        [23:0] core_d_next;
  logic        [7:0]  exp_base;

  assign e_plus1     = unb_exp + 10'sd1;
  assign core_d_next = e_plus1[0] ? {2'b01, norm_frac[22:1]} : {1'b1, norm_frac};
  // ceil((E+1)/2) via an arithmetic shift of E+2
  assign root_exp    = (e_plus1 + 10'sd1) >>> 1;
  // Biased exponent for a root of the form 1.x; the core's root is usually
  // in [0.5,1), which costs one more exponent step at normalization.
  assign exp_base    = 8'(root_exp + 10'(BIAS));

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  rm_e             rm_q;
  logic [7:0]      exp_q;
  logic [23:0]     core_d_q;
  logic [31:0]     s_q;
  logic            valid_q;
  logic            invalid_q;
  logic            issue;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pif.fsqrt) begin
          issue   = 1'b1;
          state_d = spec_hit ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (core_busy) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!core_busy) begin
          state_d = ST_DRAIN;
          cnt_d   = CW'(DRAIN_CYC);
        end
      end
      ST_DRAIN: begin
        // Leave as the count reaches zero so DRAIN lasts DRAIN_CYC enabled
        // cycles and core_q is sampled on the last of them.
        if (pif.ena) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Root normalization and rounding
  // ---------------------------------------------------------------------
  logic [30:0] root_frac;   // bits below the hidden one
  logic [7:0]  exp_norm;
  logic        rnd_inc;
  logic [31:0] root_res;

  assign root_frac = core_q[31] ? core_q[30:0] : {core_q[29:0], 1'b0};
  assign exp_norm  = exp_q - {7'd0, ~core_q[31]};
  assign rnd_inc   = round_inc(rm_q, root_frac[8], root_frac[7], |root_frac[6:0]);
  // A mantissa carry-out ripples into the exponent field, leaving the
  // fraction at zero, i.e. mantissa 1.0 with the exponent incremented.
  assign root_res  = {1'b0, exp_norm, root_frac[30:8]} + {31'd0, rnd_inc};

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rm_q      <= RM_RNE;
      exp_q     <= 8'd0;
      core_d_q  <= 24'd0;
      s_q       <= 32'd0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= (state_d == ST_DONE);
      invalid_q <= 1'b0;
      if (issue) begin
        rm_q  <= rm_e'(pif.rm);
        exp_q <= exp_base;
        if (!spec_hit) begin
          core_d_q <= core_d_next;
        end
      end
      // DONE is entered either straight from an issue (special operand) or
      // from DRAIN with the core's root now valid.
      if (state_d == ST_DONE) begin
        if (issue) begin
          s_q       <= spec_res;
          invalid_q <= spec_inv;
        end else begin
          s_q <= root_res;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign core_d      = core_d_q;
  assign core_fsqrt  = (state_q == ST_START);
  assign pif.s       = s_q;
  assign pif.valid   = valid_q;
  assign pif.invalid = invalid_q;
  assign pif.busy    = (state_q != ST_IDLE);
  assign pif.stall   = (pif.fsqrt & (state_q == ST_IDLE)) |
                       ((state_q != ST_IDLE) & (state_q != ST_DONE));

endmodule

// File: doc/fsqrt_ctrl.md
# fsqrt_ctrl

IEEE-754 single-precision square-root sequencer on the FPU's issue side. Accepts an fsqrt issue from the pipeline, unpacks the operand, and resolves special cases directly. It prepares the 24-bit fraction for the iterative Newton root core, holds the pipeline stalled while the core runs, then normalizes and rounds the core's 32-bit root into the packed result.

## Interface
- `DRAIN_CYC`, 3: number of `ena`-qualified cycles after `core_busy` falls until `core_q` is valid.
- `clk` in 1: clock.
- `clrn` in 1: asynchronous active-low reset.
- `fsqrt` in 1: issue request; sampled only in IDLE.
- `a` in 32: operand, sampled with the issue.
- `rm` in 2: rounding mode, sampled with the issue.
  - 00 = RNE, 01 = RTZ, 10 = RUP, 11 = RDN.
- `ena` in 1: pipeline enable; also advances the core's output stages.
- `core_busy` in 1: root core busy.
- `core_q` in 32: core root, value = `core_q` × 2^-31, range [0.5,1).
  - Bit 0 is sticky.
- `core_d` out 24: fraction to the core, range [0.25,1).
  - `core_d[23:22]` is never 00.
- `core_fsqrt` out 1: one-cycle start pulse to the core.
- `s` out 32: packed result; holds until the next result.
- `invalid` out 1: invalid-operation flag, qualified by `valid`.
- `valid` out 1: one-cycle result strobe.
- `stall` out 1: pipeline stall.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, DRAIN, DONE.
- IDLE, `fsqrt`=1: register `a` and `rm`, then classify the operand.
  - Special operand → DONE.
  - Otherwise → START.
- Special results:
  - ±0 → ±0.
  - +inf → 0x7F800000.
  - NaN → 0x7FC00000.
  - Negative nonzero, including -inf → 0x7FC00000 with `invalid`=1.
  - The core is never started for a special operand.
- Operand preparation: write the value as 1.f × 2^E.
  - E+1 even: `core_d` = {1,f}.
  - E+1 odd: `core_d` = {01,f[22:1]}.
  - Unbiased result exponent = ceil((E+1)/2).
- START: `core_fsqrt`=1 → WAIT_HI.
- WAIT_HI: on `core_busy`=1 → WAIT_LO.
- WAIT_LO: on `core_busy`=0 → DRAIN and load the drain counter with `DRAIN_CYC`.
- DRAIN: decrement the counter only when `ena`=1; at zero → DONE.
- DONE: latch the result, pulse `valid`, then → IDLE.
- Normalize the root:
  - If `core_q[31]`=0, shift left by 1 and decrement the exponent by 1.
  - Mantissa = 24 bits; guard = next bit; sticky = OR of the remaining bits.
- Rounding (the result is always positive):
  - RNE: increment if g & (s | lsb).
  - RUP: increment if g | s.
  - RTZ and RDN: truncate.
- Mantissa carry-out: mantissa becomes 1.0 and the exponent increments.
- Result overflow and underflow are impossible; no detection logic.
- `fsqrt` outside IDLE is ignored.
- `core_d` holds from START until DONE.

## Timing
- `stall` = `fsqrt` & IDLE | (state ∉ {IDLE, DONE}).
- `stall` is low in the DONE cycle.
- Special operand: issue at T0, `valid` at T1.
- Normal operand:
  - Issue at T0; `core_fsqrt` at T1.
  - `valid` = core busy time + `DRAIN_CYC` + 3 cycles, with `ena` held high.
- Reset values: state = IDLE; `s`=0; `core_d`=0; all single-bit outputs = 0.
- `clrn` low mid-operation: immediate return to IDLE, no `valid`. The core is reset by the same `clrn`.

## Configuration
- `FSQRT_DENORM_EN` defined: denormals (exponent 0, f ≠ 0) are normalized.
  - Shift the fraction left by lzc+1.
  - E = -126 - lzc - 1.
  - Then process as a normal operand.
- `FSQRT_DENORM_EN` undefined: denormals flush to a signed zero; completes in 1 cycle like a special operand.

## Structure
- `fsqrt_pkg` holds:
  - State encoding.
  - `BIAS` = 127.
  - `QNAN` = 32'h7FC00000 and `PINF` = 32'h7F800000.
  - Rounding-mode codes.
- Sub-module `lzc23`: combinational leading-zero counter on f. Instantiated only under `FSQRT_DENORM_EN`.

## Test plan
All cases use a behavioral exact-root core model.
- a=0x40800000 (4.0), rm=RNE → `s`=0x40000000, `invalid`=0.
- a=0x40000000, rm=RNE → 0x3FB504F3; same operand with rm=RUP → 0x3FB504F4.
- a=0xBF800000 → 0x7FC00000, `invalid`=1, `valid` at T1, `core_fsqrt` never asserted; a=0x7F800000 → 0x7F800000.
- a=0x00000001 → 0x1A3504F3 with the macro defined; 0x00000000 with it undefined.
- `ena` held low for 5 cycles during DRAIN → `valid` delayed exactly 5 cycles; `stall` stays high throughout.
- `clrn` pulsed low in WAIT_LO → state IDLE, `stall`=0, no `valid`; the next issue of 4.0 → 0x40000000.
